// File: rtl/obf_pkg.sv
// obf_pkg -- shared definitions for the obfuscation restore scheduler.
//   state_t    : scheduler states RUN, FLIP, RESTORE, LOCKED
//   TAPS_<n>   : Fibonacci LFSR feedback masks, one per supported width
//   lfsr_taps  : selects the feedback mask for a given LFSR width (2..11)
// Mask convention: the register shifts toward the MSB and the feedback bit
// enters at bit 0; a set mask bit k feeds state[k] into the XOR.  For width L
// and primitive trinomial x^L + x^m + 1 the mask is bit(L-1) | bit(L-1-m).
package obf_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLIP    = 2'd1,
        RESTORE = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam logic [31:0] TAPS_2  = 32'h0000_0003; // x^2  + x   + 1
    localparam logic [31:0] TAPS_3  = 32'h0000_0005; // x^3  + x^2 + 1
    localparam logic [31:0] TAPS_4  = 32'h0000_0009; // x^4  + x^3 + 1
    localparam logic [31:0] TAPS_5  = 32'h0000_0014; // x^5  + x^2 + 1
    localparam logic [31:0] TAPS_6  = 32'h0000_0021; // x^6  + x^5 + 1
    localparam logic [31:0] TAPS_7  = 32'h0000_0041; // x^7  + x^6 + 1
    localparam logic [31:0] TAPS_8  = 32'h0000_008E; // x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [31:0] TAPS_9  = 32'h0000_0108; // x^9  + x^5 + 1
    localparam logic [31:0] TAPS_10 = 32'h0000_0204; // x^10 + x^7 + 1
    localparam logic [31:0] TAPS_11 = 32'h0000_0402; // x^11 + x^9 + 1

    function automatic logic [31:0] lfsr_taps(input int len);
        case (len)
            2:       return TAPS_2;
            3:       return TAPS_3;
            4:       return TAPS_4;
            5:       return TAPS_5;
            6:       return TAPS_6;
            7:       return TAPS_7;
            8:       return TAPS_8;
            9:       return TAPS_9;
            10:      return TAPS_10;
            11:      return TAPS_11;
            default: return TAPS_5;
        endcase
    endfunction

endpackage

// File: rtl/obf_lfsr.sv
// obf_lfsr -- Fibonacci maximal-length LFSR.
//   clk   : clock
//   reset : synchronous active-high; loads seed (a zero seed becomes 1,
//           since the all-zero state would lock the register)
//   seed  : LEN-bit load value
//   step  : advance one step this cycle
//   state : current register value
module obf_lfsr
    import obf_pkg::*;
#(
    parameter int LEN = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [LEN-1:0] seed,
    input  logic           step,
    output logic [LEN-1:0] state
);

    localparam logic [31:0]    TAPS_FULL = lfsr_taps(LEN);
    localparam logic [LEN-1:0] TAPS      = TAPS_FULL[LEN-1:0];
    localparam logic [LEN-1:0] ONE       = {{(LEN-1){1'b0}}, 1'b1};

    logic [LEN-1:0] state_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= (seed == '0) ? ONE : seed;
        end else if (step) begin
            state_reg <= {state_reg[LEN-2:0], ^(state_reg & TAPS)};
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/obf_restore_scheduler.sv
// obf_restore_scheduler -- schedules corruption flips and key-driven restores.
//   clk, reset     : clock, synchronous active-high reset
//   en             : scheduler enable (gates RUN progress only)
//   lfsr_seed      : LFSR seed loaded on reset
//   in_vec         : watched primary inputs, compared against KEY
//   fsm_flip       : one-hot corruption select (zero in RUN/RESTORE)
//   freeze         : flop-bank hold, high throughout FLIP
//   restore_flag   : one-cycle strobe in RESTORE
//   comparator_sig : combinational in_vec == KEY
//   busy           : high whenever not in RUN
//   flip_count     : FLIP entries since reset, saturating at 255
//                    (present only when OBF_FLIP_COUNT_EN is defined)
module obf_restore_scheduler
    import obf_pkg::*;
#(
    parameter int                   LFSR_LEN    = 5,
    parameter int                   COUNTER_LEN = 7,
    parameter int                   FLIP_W      = 3,
    parameter int                   DEADLINE    = 5,
    parameter int                   INPUT_LEN   = 4,
    parameter logic [INPUT_LEN-1:0] KEY         = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [LFSR_LEN-1:0]  lfsr_seed,
    input  logic [INPUT_LEN-1:0] in_vec,
    output logic [FLIP_W-1:0]    fsm_flip,
    output logic                 freeze,
    output logic                 restore_flag,
    output logic                 comparator_sig,
    output logic                 busy
`ifdef OBF_FLIP_COUNT_EN
    ,
    output logic [7:0]           flip_count
`endif
);

    localparam logic [COUNTER_LEN-1:0] CNT_MAX = '1;
    localparam logic [COUNTER_LEN-1:0] DL_M1   = COUNTER_LEN'(DEADLINE - 1);

    state_t                  state_reg;
    logic [COUNTER_LEN-1:0]  cnt_reg;        // RUN cycles in RUN, dwell cycles in FLIP
    logic [FLIP_W-1:0]       fsm_flip_reg;
    logic                    freeze_reg;
    logic                    restore_flag_reg;
    logic                    busy_reg;

    logic [LFSR_LEN-1:0]     lfsr_state;
    logic                    lfsr_step;
    logic                    run_fire;
    logic [31:0]             flip_idx;
    logic [FLIP_W-1:0]       flip_sel;

    // The LFSR only advances on enabled RUN cycles, including the cycle
    // that launches a FLIP, so the pattern keeps moving across restores.
    assign lfsr_step = (state_reg == RUN) && en;

    obf_lfsr #(
        .LEN (LFSR_LEN)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (lfsr_seed),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    assign comparator_sig = (in_vec == KEY);

    // Launch on a random opportunity after the deadline, or unconditionally
    // at the counter ceiling so the counter never wraps.
    assign run_fire = en && (((cnt_reg >= DL_M1) && lfsr_state[0]) || (cnt_reg == CNT_MAX));

    // Corruption target is taken from the pre-step LFSR value that fired.
    assign flip_idx = 32'(lfsr_state) % 32'(FLIP_W);

    for (genvar gi = 0; gi < FLIP_W; gi++) begin : g_flip_sel
        assign flip_sel[gi] = (flip_idx == 32'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= RUN;
            cnt_reg          <= '0;
            fsm_flip_reg     <= '0;
            freeze_reg       <= 1'b0;
            restore_flag_reg <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (run_fire) begin
                        state_reg    <= FLIP;
                        cnt_reg      <= '0;
                        fsm_flip_reg <= flip_sel;
                        freeze_reg   <= 1'b1;
                        busy_reg     <= 1'b1;
                    end else if (en) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                FLIP: begin
                    if (comparator_sig) begin
                        state_reg        <= RESTORE;
                        fsm_flip_reg     <= '0;
                        freeze_reg       <= 1'b0;
                        restore_flag_reg <= 1'b1;
                    end else if (cnt_reg == DL_M1) begin
                        // Dwell expired: keep the corruption select, release hold.
                        state_reg  <= LOCKED;
                        freeze_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RESTORE: begin
                    state_reg        <= RUN;
                    cnt_reg          <= '0;
                    restore_flag_reg <= 1'b0;
                    busy_reg         <= 1'b0;
                end
                LOCKED: begin
                    if (comparator_sig) begin
                        state_reg        <= RESTORE;
                        fsm_flip_reg     <= '0;
                        restore_flag_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg        <= RUN;
                    cnt_reg          <= '0;
                    fsm_flip_reg     <= '0;
                    freeze_reg       <= 1'b0;
                    restore_flag_reg <= 1'b0;
                    busy_reg         <= 1'b0;
                end
            endcase
        end
    end

`ifdef OBF_FLIP_COUNT_EN
    logic [7:0] flip_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            flip_count_reg <= '0;
        end else if ((state_reg == RUN) && run_fire && (flip_count_reg != 8'hFF)) begin
            flip_count_reg <= flip_count_reg + 8'd1;
        end
    end

    assign flip_count = flip_count_reg;
`endif

    assign fsm_flip     = fsm_flip_reg;
    assign freeze       = freeze_reg;
    assign restore_flag = restore_flag_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_obf_restore_scheduler.sv
// tb_obf_restore_scheduler -- directed bench for obf_restore_scheduler.
// Instance u_dut uses default parameters; u_dut_b uses DEADLINE=126 to reach
// the counter-ceiling launch.  LFSR (x^5+x^2+1) sequence from 1:
//   1 2 4 9 18 5 11 22 12 25 19 7 15 31 30 28 24 17 3 6 13 27 23 14 29 26 21 10 20 8 16
module tb_obf_restore_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       reset_b;
    logic       en;
    logic [4:0] seed;
    logic [4:0] seed_b;
    logic [3:0] in_vec;

    logic [2:0] fsm_flip, fsm_flip_b;
    logic       freeze, freeze_b;
    logic       restore_flag, restore_flag_b;
    logic       comparator_sig, comparator_sig_b;
    logic       busy, busy_b;
`ifdef OBF_FLIP_COUNT_EN
    logic [7:0] flip_count, flip_count_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    obf_restore_scheduler u_dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .lfsr_seed      (seed),
        .in_vec         (in_vec),
        .fsm_flip       (fsm_flip),
        .freeze         (freeze),
        .restore_flag   (restore_flag),
        .comparator_sig (comparator_sig),
        .busy           (busy)
`ifdef OBF_FLIP_COUNT_EN
        ,
        .flip_count     (flip_count)
`endif
    );

    obf_restore_scheduler #(
        .DEADLINE (126)
    ) u_dut_b (
        .clk            (clk),
        .reset          (reset_b),
        .en             (en),
        .lfsr_seed      (seed_b),
        .in_vec         (in_vec),
        .fsm_flip       (fsm_flip_b),
        .freeze         (freeze_b),
        .restore_flag   (restore_flag_b),
        .comparator_sig (comparator_sig_b),
        .busy           (busy_b)
`ifdef OBF_FLIP_COUNT_EN
        ,
        .flip_count     (flip_count_b)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        reset_b = 1'b1;
        en      = 1'b1;
        seed    = 5'b00000;
        seed_b  = 5'd10;
        in_vec  = 4'hF;
        tick();
        tick();

        // Reset values, zero seed
        check("rst_flip", 32'(fsm_flip), 32'h0);
        check("rst_freeze", 32'(freeze), 32'h0);
        check("rst_restore", 32'(restore_flag), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("cmp_nokey", 32'(comparator_sig), 32'h0);
`ifdef OBF_FLIP_COUNT_EN
        check("rst_count", 32'(flip_count), 32'h0);
`endif
        reset = 1'b0;

        // LFSR 1,2,4,9,18 -> no launch; 5 at counter 5 -> FLIP, idx 5%3=2
        for (int i = 0; i < 5; i++) begin
            tick();
            check("run1_busy", 32'(busy), 32'h0);
        end
        tick();
        $display("step: first FLIP entry");
        check("flip1_sel", 32'(fsm_flip), 32'h4);
        check("flip1_freeze", 32'(freeze), 32'h1);
        check("flip1_busy", 32'(busy), 32'h1);

        // en low during dwell does not stall it; no key -> LOCKED after 5 cycles
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("dwell_freeze", 32'(freeze), 32'h1);
            check("dwell_sel", 32'(fsm_flip), 32'h4);
        end
        tick();
        $display("step: LOCKED entry");
        check("lock_freeze", 32'(freeze), 32'h0);
        check("lock_busy", 32'(busy), 32'h1);
        check("lock_sel", 32'(fsm_flip), 32'h4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lock_hold_busy", 32'(busy), 32'h1);
            check("lock_hold_sel", 32'(fsm_flip), 32'h4);
            check("lock_hold_rst", 32'(restore_flag), 32'h0);
        end
        in_vec = 4'h0;
        #1;
        check("cmp_key", 32'(comparator_sig), 32'h1);
        tick();
        $display("step: RESTORE from LOCKED");
        check("rest1_flag", 32'(restore_flag), 32'h1);
        check("rest1_sel", 32'(fsm_flip), 32'h0);
        check("rest1_freeze", 32'(freeze), 32'h0);
        check("rest1_busy", 32'(busy), 32'h1);
        in_vec = 4'hF;
        en = 1'b1;
        tick();
        check("run2_flag", 32'(restore_flag), 32'h0);
        check("run2_busy", 32'(busy), 32'h0);

        // Counter restarts at 0, LFSR continues at 11: 11,22,12,25 no launch; 19 -> idx 1
        for (int i = 0; i < 4; i++) begin
            tick();
            check("run2_wait", 32'(busy), 32'h0);
        end
        tick();
        $display("step: second FLIP entry after restore");
        check("flip2_sel", 32'(fsm_flip), 32'h2);
        check("flip2_busy", 32'(busy), 32'h1);

        // Seed 1, en held low for 20 RUN cycles in the middle
        reset = 1'b1;
        seed  = 5'b00001;
        tick();
        check("rst2_busy", 32'(busy), 32'h0);
        check("rst2_sel", 32'(fsm_flip), 32'h0);
        reset = 1'b0;
        tick();
        tick();
        check("pre_hold_busy", 32'(busy), 32'h0);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_busy", 32'(busy), 32'h0);
            check("hold_sel", 32'(fsm_flip), 32'h0);
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_hold_busy", 32'(busy), 32'h0);
        end
        tick();
        $display("step: FLIP after enable hold");
        check("flip3_sel", 32'(fsm_flip), 32'h4);
        check("flip3_freeze", 32'(freeze), 32'h1);

        // Key presented on the 2nd FLIP cycle
        tick();
        in_vec = 4'h0;
        tick();
        $display("step: RESTORE from FLIP");
        check("rest2_flag", 32'(restore_flag), 32'h1);
        check("rest2_sel", 32'(fsm_flip), 32'h0);
        check("rest2_freeze", 32'(freeze), 32'h0);
        check("rest2_busy", 32'(busy), 32'h1);
        in_vec = 4'hF;
        tick();
        check("run3_flag", 32'(restore_flag), 32'h0);
        check("run3_busy", 32'(busy), 32'h0);
        check("run3_sel", 32'(fsm_flip), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("run3_wait", 32'(busy), 32'h0);
        end
        tick();
        check("flip4_sel", 32'(fsm_flip), 32'h2);
        check("flip4_busy", 32'(busy), 32'h1);
`ifdef OBF_FLIP_COUNT_EN
        check("count_two", 32'(flip_count), 32'h2);
`endif

        // Reset on the 3rd FLIP cycle, with the key present on the same edge
        tick();
        tick();
        check("flip4_c3_freeze", 32'(freeze), 32'h1);
        reset  = 1'b1;
        in_vec = 4'h0;
        tick();
        $display("step: reset mid-dwell");
        check("midrst_sel", 32'(fsm_flip), 32'h0);
        check("midrst_freeze", 32'(freeze), 32'h0);
        check("midrst_flag", 32'(restore_flag), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
`ifdef OBF_FLIP_COUNT_EN
        check("midrst_count", 32'(flip_count), 32'h0);
`endif
        reset  = 1'b0;
        in_vec = 4'hF;

        // Instance B: seed 10, lfsr even at counters 125,126,127 -> forced launch at 127
        reset_b = 1'b0;
        for (int i = 0; i < 127; i++) begin
            tick();
            check("b_run_busy", 32'(busy_b), 32'h0);
        end
        tick();
        $display("step: forced FLIP at counter ceiling");
        check("b_force_busy", 32'(busy_b), 32'h1);
        check("b_force_sel", 32'(fsm_flip_b), 32'h2);
        check("b_force_freeze", 32'(freeze_b), 32'h1);
        check("b_force_flag", 32'(restore_flag_b), 32'h0);
        check("b_cmp", 32'(comparator_sig_b), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/obf_restore_scheduler.md
OBF_RESTORE_SCHEDULER -- requirements
Module: obf_restore_scheduler

Interface
REQ-001 SHALL have parameter LFSR_LEN, default 5, LFSR width.
REQ-002 SHALL have parameter COUNTER_LEN, default 7, cycle-counter width.
REQ-003 SHALL have parameter FLIP_W, default 3, flip-vector width; legal range 1..2**LFSR_LEN.
REQ-004 SHALL have parameter DEADLINE, default 5, minimum RUN cycles before a flip may fire; legal range 1..2**COUNTER_LEN-2.
REQ-005 SHALL have parameters INPUT_LEN, default 4, watched-input width, and KEY, default 0, unlock pattern of width INPUT_LEN.
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports: en input 1 scheduler enable; lfsr_seed input LFSR_LEN seed; in_vec input INPUT_LEN watched primary inputs.
REQ-009 SHALL have outputs: fsm_flip FLIP_W one-hot corruption select; freeze 1 flop-bank hold; restore_flag 1 restore strobe; comparator_sig 1 key match; busy 1 not-RUN indicator.

Function
REQ-010 SHALL implement states RUN, FLIP, RESTORE, LOCKED.
REQ-011 SHALL use a Fibonacci maximal-length LFSR, shifting one step per cycle in RUN only.
REQ-012 SHALL drive comparator_sig combinationally high when in_vec equals KEY, in every state.
REQ-013 RUN: counter increments by 1 per cycle while en=1; while en=0, counter and LFSR hold and no transition occurs.
REQ-014 RUN->FLIP when en=1, counter >= DEADLINE-1 and lfsr[0]=1; also forced when the counter equals 2**COUNTER_LEN-1 (no wrap).
REQ-015 On entering FLIP, fsm_flip SHALL be one-hot at index (lfsr value mod FLIP_W), registered, stable for the entire FLIP dwell; freeze=1 throughout FLIP.
REQ-016 FLIP dwell SHALL be at most DEADLINE cycles; if comparator_sig=1 in any FLIP cycle, next state RESTORE.
REQ-017 If the FLIP dwell expires with no key match, next state LOCKED.
REQ-018 RESTORE SHALL last exactly one cycle: restore_flag=1, fsm_flip=0, freeze=0; then RUN with counter cleared to 0; LFSR continues from its current value.
REQ-019 LOCKED SHALL hold fsm_flip at its last one-hot value and freeze=0; leave only through reset, or through comparator_sig=1, which yields RESTORE next cycle.
REQ-020 busy SHALL be 1 in FLIP, RESTORE and LOCKED; 0 in RUN.
REQ-021 fsm_flip SHALL be all-zero in RUN and RESTORE; never more than one bit set.
REQ-022 en=0 in FLIP/LOCKED SHALL NOT stall the dwell counter or the exit conditions.

Reset
REQ-023 On reset: state RUN, counter 0, fsm_flip 0, freeze 0, restore_flag 0, busy 0.
REQ-024 On reset, LFSR SHALL load lfsr_seed; a zero seed SHALL be replaced by 1.
REQ-025 Reset asserted in any state, including mid-dwell, SHALL take priority over all transitions on the same edge.

Configuration
REQ-026 Macro OBF_FLIP_COUNT_EN, when defined, SHALL add output flip_count (8 bits): the number of FLIP entries since reset, saturating at 255, reset to 0.
REQ-027 Without OBF_FLIP_COUNT_EN, the port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 A shared package obf_pkg SHALL hold the state enum (RUN, FLIP, RESTORE, LOCKED) and the LFSR tap-mask constants per LFSR_LEN.
REQ-029 The LFSR SHALL be a sub-module obf_lfsr with ports clk, reset, load seed, step enable and state out.

Verification
REQ-030 Seed 5'b00000, en=1, KEY never presented -> LFSR starts at 1; first FLIP no earlier than cycle DEADLINE-1 after reset.
REQ-031 Seed 5'b00001, en=1; present in_vec=KEY on the 2nd FLIP cycle -> RESTORE next cycle with restore_flag=1 for one cycle, then RUN with counter=0.
REQ-032 Enter FLIP, withhold KEY for 5 cycles -> LOCKED with fsm_flip unchanged and busy=1; then present KEY -> RESTORE, then RUN.
REQ-033 Hold en=0 for 20 cycles in RUN -> counter, LFSR and state all unchanged; fsm_flip=0.
REQ-034 Force lfsr[0]=0 for 127 consecutive RUN cycles (COUNTER_LEN=7) -> forced FLIP at counter=127; no wrap.
REQ-035 Assert reset during the 3rd FLIP cycle -> next cycle state RUN and all outputs at their reset values; with OBF_FLIP_COUNT_EN defined, flip_count=0.
